// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO: drains the read port into a 3-entry
// buffer and presents the words as a framed valid/ready stream with a word count.
module fifo_stream_reader #(
    parameter int WIDTH = 1,
    parameter int FWFT  = 0,
    parameter int BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fifo_empty,
    output logic             o_fifo_ren,
    input  logic [WIDTH-1:0] i_fifo_rdata,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    output logic [15:0]      o_count
);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

    logic [WIDTH-1:0] buf_r [3];
    logic [1:0]       occ_r;
    logic [1:0]       head_r;
    logic [1:0]       tail_r;
    logic             pend_r;
    logic [BW-1:0]    beat_r;
    logic [15:0]      cnt_r;

    logic [2:0]       inflight_s;
    logic             ren_s;
    logic             cap_s;
    logic             pop_s;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read issue looks only at registered state, so i_tready never reaches o_fifo_ren.
    always_comb begin
        inflight_s = {1'b0, occ_r} + {2'b00, pend_r};
        ren_s      = ~i_rst & ~i_fifo_empty & (inflight_s <= 3'd2);
        cap_s      = (FWFT != 0) ? ren_s : pend_r;
        pop_s      = (occ_r != 2'd0) & i_tready;
    end

    assign o_fifo_ren = ren_s;
    assign o_tvalid   = (occ_r != 2'd0);
    assign o_tdata    = buf_r[head_r];
    assign o_tlast    = (occ_r != 2'd0) & (beat_r == BEAT_LAST);
    assign o_count    = cnt_r;

    // Buffer, pointers, occupancy, framing and count; a read in flight at reset is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            occ_r  <= 2'd0;
            head_r <= 2'd0;
            tail_r <= 2'd0;
            pend_r <= 1'b0;
            beat_r <= '0;
            cnt_r  <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            if (cap_s) begin
                buf_r[tail_r] <= i_fifo_rdata;
                tail_r        <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
                beat_r <= (beat_r == BEAT_LAST) ? '0 : beat_r + BW'(1);
                cnt_r  <= cnt_r + 16'd1;
            end
            case ({cap_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
            pend_r <= (FWFT != 0) ? 1'b0 : ren_s;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a registered-read instance (BURST=4) and a FWFT instance
// (BURST=1), each fed by a behavioural FIFO and checked against a word scoreboard.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_pass = 0;
    int          n_checks = 0;
    int          cyc = 0;

    logic        empty0 = 1'b1, ren0, tvalid0, tready0 = 1'b0, tlast0, gap0 = 1'b0;
    logic [15:0] rdata0 = 16'd0, tdata0, count0;
    logic        empty1 = 1'b1, ren1, tvalid1, tready1 = 1'b0, tlast1, gap1 = 1'b0;
    logic [15:0] rdata1 = 16'd0, tdata1, count1;

    logic [15:0] src0[$], exp0[$], src1[$], exp1[$];
    int          acc0 = 0, acc1 = 0;
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic [15:0] held0 = 16'd0, held1 = 16'd0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(16), .FWFT(0), .BURST(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_fifo_empty(empty0), .o_fifo_ren(ren0),
        .i_fifo_rdata(rdata0), .o_tdata(tdata0), .o_tvalid(tvalid0),
        .i_tready(tready0), .o_tlast(tlast0), .o_count(count0)
    );

    fifo_stream_reader #(.WIDTH(16), .FWFT(1), .BURST(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_fifo_empty(empty1), .o_fifo_ren(ren1),
        .i_fifo_rdata(rdata1), .o_tdata(tdata1), .o_tvalid(tvalid1),
        .i_tready(tready1), .o_tlast(tlast1), .o_count(count1)
    );

    // Behavioural FIFO read ports: registered data for dut0, show-ahead data for dut1.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst && ren0 && src0.size() > 0) rdata0 <= src0.pop_front();
            empty0 <= (src0.size() == 0) || gap0;
            if (!rst && ren1 && src1.size() > 0) void'(src1.pop_front());
            empty1 <= (src1.size() == 0) || gap1;
            rdata1 <= (src1.size() > 0) ? src1[0] : 16'd0;
        end
    end

    // Scoreboard and stall-stability monitor, sampled on the falling edge.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc0 = 0; acc1 = 0; stall0 = 1'b0; stall1 = 1'b0;
            end else begin
                if (stall0) begin
                    n_checks++;
                    if (tvalid0 !== 1'b1 || tdata0 !== held0)
                        $display("FAIL stall0: got valid=%b data=%h expected valid=1 data=%h", tvalid0, tdata0, held0);
                    else n_pass++;
                end
                if (tvalid0 && tready0) begin
                    n_checks++;
                    if (exp0.size() == 0) begin
                        $display("FAIL extra0: got word %h expected none", tdata0);
                    end else begin
                        e = exp0.pop_front();
                        if (tdata0 !== e || tlast0 !== ((acc0 % 4) == 3))
                            $display("FAIL word0: got %h last=%b expected %h last=%b", tdata0, tlast0, e, ((acc0 % 4) == 3));
                        else n_pass++;
                    end
                    acc0++;
                end
                stall0 = tvalid0 && !tready0;
                held0  = tdata0;

                if (stall1) begin
                    n_checks++;
                    if (tvalid1 !== 1'b1 || tdata1 !== held1)
                        $display("FAIL stall1: got valid=%b data=%h expected valid=1 data=%h", tvalid1, tdata1, held1);
                    else n_pass++;
                end
                if (tvalid1 && tready1) begin
                    n_checks++;
                    if (exp1.size() == 0) begin
                        $display("FAIL extra1: got word %h expected none", tdata1);
                    end else begin
                        e = exp1.pop_front();
                        if (tdata1 !== e || tlast1 !== 1'b1)
                            $display("FAIL word1: got %h last=%b expected %h last=1", tdata1, tlast1, e);
                        else n_pass++;
                    end
                    acc1++;
                end
                stall1 = tvalid1 && !tready1;
                held1  = tdata1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; tready0 = 1'b0; tready1 = 1'b0; gap0 = 1'b0; gap1 = 1'b0;
        exp0 = src0; exp1 = src1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        src0.push_back(16'h00AA); exp0.push_back(16'h00AA);
        repeat (3) @(negedge clk);
        n_checks += 10;
        if (ren0 !== 1'b0) $display("FAIL rst_ren0: got %b expected 0", ren0); else n_pass++;
        if (tvalid0 !== 1'b0) $display("FAIL rst_valid0: got %b expected 0", tvalid0); else n_pass++;
        if (tdata0 !== 16'd0) $display("FAIL rst_data0: got %h expected 0", tdata0); else n_pass++;
        if (tlast0 !== 1'b0) $display("FAIL rst_last0: got %b expected 0", tlast0); else n_pass++;
        if (count0 !== 16'd0) $display("FAIL rst_count0: got %0d expected 0", count0); else n_pass++;
        if (ren1 !== 1'b0) $display("FAIL rst_ren1: got %b expected 0", ren1); else n_pass++;
        if (tvalid1 !== 1'b0) $display("FAIL rst_valid1: got %b expected 0", tvalid1); else n_pass++;
        if (tdata1 !== 16'd0) $display("FAIL rst_data1: got %h expected 0", tdata1); else n_pass++;
        if (tlast1 !== 1'b0) $display("FAIL rst_last1: got %b expected 0", tlast1); else n_pass++;
        if (count1 !== 16'd0) $display("FAIL rst_count1: got %0d expected 0", count1); else n_pass++;
        step();
        rst = 1'b0; tready0 = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_basic();
        int c0, c1, ones;
        do_reset();
        tready0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin src0.push_back(16'(i)); exp0.push_back(16'(i)); end
        c0 = -100; c1 = 0; ones = 1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (ren0) begin c0 = cyc; break; end end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (tvalid0) begin c1 = cyc; break; end end
        n_checks++;
        if (c1 - c0 !== 2) $display("FAIL latency0: got %0d expected 2", c1 - c0); else n_pass++;
        for (int i = 0; i < 7; i++) begin @(negedge clk); if (tvalid0) ones++; end
        n_checks++;
        if (ones !== 8) $display("FAIL burst0: got %0d valid cycles expected 8", ones); else n_pass++;
        repeat (3) step();
        n_checks += 2;
        if (count0 !== 16'd8) $display("FAIL count_basic: got %0d expected 8", count0); else n_pass++;
        if (exp0.size() !== 0) $display("FAIL drain_basic: got %0d left expected 0", exp0.size()); else n_pass++;
    endtask

    task automatic test_back_pressure();
        int nren, ones;
        do_reset();
        for (int i = 0; i < 10; i++) begin src0.push_back(16'h10 + 16'(i)); exp0.push_back(16'h10 + 16'(i)); end
        nren = 0; ones = 0;
        repeat (20) begin @(negedge clk); if (ren0) nren++; end
        n_checks += 3;
        if (nren !== 3) $display("FAIL bp_reads: got %0d expected 3", nren); else n_pass++;
        if (tdata0 !== 16'h10) $display("FAIL bp_head: got %h expected 0010", tdata0); else n_pass++;
        if (ren0 !== 1'b0) $display("FAIL bp_ren: got %b expected 0", ren0); else n_pass++;
        step();
        tready0 = 1'b1;
        repeat (10) begin @(negedge clk); if (tvalid0) ones++; end
        step();
        n_checks += 2;
        if (ones !== 10) $display("FAIL bp_bubble: got %0d valid cycles expected 10", ones); else n_pass++;
        if (count0 !== 16'd10) $display("FAIL bp_count: got %0d expected 10", count0); else n_pass++;
    endtask

    task automatic test_random_gaps();
        int pushed, n;
        logic [15:0] w;
        do_reset();
        pushed = 0;
        for (int c = 0; c < 20000; c++) begin
            step();
            tready0 = ($urandom_range(0, 9) < 6);
            gap0    = ($urandom_range(0, 9) < 2);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n && pushed < 1000; k++) begin
                w = 16'($urandom);
                src0.push_back(w); exp0.push_back(w);
                pushed++;
            end
            if (pushed == 1000 && exp0.size() == 0) break;
        end
        tready0 = 1'b0; gap0 = 1'b0;
        step();
        n_checks += 2;
        if (exp0.size() !== 0) $display("FAIL rand_timeout: got %0d left expected 0", exp0.size()); else n_pass++;
        if (count0 !== 16'd1000) $display("FAIL rand_count: got %0d expected 1000", count0); else n_pass++;
    endtask

    task automatic test_fwft_single();
        int c0, c1, ones;
        do_reset();
        tready1 = 1'b1;
        for (int i = 0; i < 6; i++) begin src1.push_back(16'h21 + 16'(i)); exp1.push_back(16'h21 + 16'(i)); end
        c0 = -100; c1 = 0; ones = 1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (ren1) begin c0 = cyc; break; end end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (tvalid1) begin c1 = cyc; break; end end
        n_checks++;
        if (c1 - c0 !== 1) $display("FAIL latency1: got %0d expected 1", c1 - c0); else n_pass++;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (tvalid1) ones++; end
        repeat (2) step();
        n_checks += 2;
        if (ones !== 6) $display("FAIL burst1: got %0d valid cycles expected 6", ones); else n_pass++;
        if (count1 !== 16'd6) $display("FAIL fwft_count: got %0d expected 6", count1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin src0.push_back(16'h31 + 16'(i)); exp0.push_back(16'h31 + 16'(i)); end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (tvalid0) break; end
        @(posedge clk);
        #2;
        n_checks += 2;
        if (tvalid0 !== 1'b1) $display("FAIL mid_valid_pre: got %b expected 1", tvalid0); else n_pass++;
        if (ren0 !== 1'b0) $display("FAIL mid_ren_pre: got %b expected 0", ren0); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (tvalid0 !== 1'b0) $display("FAIL mid_valid: got %b expected 0", tvalid0); else n_pass++;
        if (tdata0 !== 16'd0) $display("FAIL mid_data: got %h expected 0", tdata0); else n_pass++;
        if (tlast0 !== 1'b0) $display("FAIL mid_last: got %b expected 0", tlast0); else n_pass++;
        if (ren0 !== 1'b0) $display("FAIL mid_ren: got %b expected 0", ren0); else n_pass++;
        exp0 = src0;
        @(negedge clk);
        step();
        rst = 1'b0; tready0 = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (tvalid0) break; end
        n_checks++;
        if (tdata0 !== 16'h34) $display("FAIL mid_first: got %h expected 0034", tdata0); else n_pass++;
        repeat (6) step();
        n_checks++;
        if (count0 !== 16'd3) $display("FAIL mid_count: got %0d expected 3", count0); else n_pass++;
    endtask

    task automatic test_count_wrap();
        do_reset();
        tready1 = 1'b1;
        for (int i = 0; i < 65537; i++) begin src1.push_back(16'(i)); exp1.push_back(16'(i)); end
        for (int c = 0; c < 70000 && exp1.size() != 0; c++) step();
        step();
        n_checks += 2;
        if (exp1.size() !== 0) $display("FAIL wrap_timeout: got %0d left expected 0", exp1.size()); else n_pass++;
        if (count1 !== 16'd1) $display("FAIL wrap_count: got %0d expected 1", count1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_random_gaps();
        test_fwft_single();
        test_reset_mid();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
